// File: rtl/memcpy_sched_pkg.sv
// memcpy_sched_pkg
//   Shared definitions for the memcpy burst scheduler: the scheduler state
//   encoding, the page size that no burst may cross, and the AXI len width.
//   Optional feature macro used by the top level: MEMCPY_SCHED_PERF_EN.
package memcpy_sched_pkg;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned AXI_LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

endpackage

// File: rtl/memcpy_chunk_calc.sv
// memcpy_chunk_calc
//   Combinational burst sizing: chunk = min(rem, max burst bytes,
//   bytes left in the source page, bytes left in the target page).
//   Ports:
//     rem   - remaining job bytes (beat aligned, non-zero when used)
//     src   - page offset of the current source address
//     dst   - page offset of the current target address
//     chunk - bytes for this burst (1..PAGE_BYTES)
//     len   - AXI len for this burst (beats - 1)
module memcpy_chunk_calc
    import memcpy_sched_pkg::*;
#(
    parameter int unsigned BEAT_BYTES      = 64,
    parameter int unsigned MAX_BURST_BEATS = 64
) (
    input  logic [63:0]          rem,
    input  logic [11:0]          src,
    input  logic [11:0]          dst,
    output logic [12:0]          chunk,
    output logic [AXI_LEN_W-1:0] len
);

    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [12:0] MAX_CHUNK  = 13'(MAX_BURST_BEATS * BEAT_BYTES);

    logic [12:0] src_room;
    logic [12:0] dst_room;
    logic [12:0] cap;

    always_comb begin
        src_room = 13'(PAGE_BYTES) - {1'b0, src};
        dst_room = 13'(PAGE_BYTES) - {1'b0, dst};
        cap      = MAX_CHUNK;
        if (src_room < cap) cap = src_room;
        if (dst_room < cap) cap = dst_room;
        chunk = (rem < 64'(cap)) ? rem[12:0] : cap;
        len   = AXI_LEN_W'((chunk >> BEAT_SHIFT) - 13'd1);
    end

endmodule

// File: rtl/memcpy_burst_scheduler.sv
// memcpy_burst_scheduler
//   Splits one memcpy job into paired AXI read/write burst commands that
//   never cross a 4 KB page on either side, limits outstanding write bursts
//   and raises pattern_memcpy_done once every write response has returned.
//   Ports:
//     pattern_memcpy_enable         - level enable; rising edge in IDLE starts a job
//     pattern_source/target_address - job byte addresses
//     pattern_total_number          - job length in bytes
//     rd_cmd_* / wr_cmd_*           - burst command handshakes (valid/ready/addr/len)
//     wr_resp_done                  - one pulse per completed write burst
//     pattern_memcpy_done           - job complete (held until enable drops)
//     sched_busy / sched_error      - not idle / misaligned job parameters
//     perf_cycles                   - active-cycle count (only with MEMCPY_SCHED_PERF_EN)
module memcpy_burst_scheduler
    import memcpy_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned BEAT_BYTES      = 64,
    parameter int unsigned MAX_BURST_BEATS = 64,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pattern_memcpy_enable,
    input  logic [ADDR_WIDTH-1:0] pattern_source_address,
    input  logic [ADDR_WIDTH-1:0] pattern_target_address,
    input  logic [63:0]           pattern_total_number,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [AXI_LEN_W-1:0]  rd_cmd_len,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [AXI_LEN_W-1:0]  wr_cmd_len,
    input  logic                  wr_resp_done,
    output logic                  pattern_memcpy_done,
`ifdef MEMCPY_SCHED_PERF_EN
    output logic [31:0]           perf_cycles,
`endif
    output logic                  sched_busy,
    output logic                  sched_error
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LOW = ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [63:0]           LEN_LOW  = 64'(BEAT_BYTES - 1);

    sched_state_e          state_q, state_d;
    logic                  enable_q;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [63:0]           rem_q;
    logic [12:0]           chunk_q;
    logic [AXI_LEN_W-1:0]  len_q;
    logic                  rd_hs_q, wr_hs_q, launched_q, abort_q, error_q;
    logic [CNT_W-1:0]      out_cnt_q, cnt_next;

    logic [12:0]           calc_chunk;
    logic [AXI_LEN_W-1:0]  calc_len;
    logic [63:0]           total_al;
    logic                  start, can_launch, issue_live;
    logic                  rd_fire, wr_fire, burst_end, resp_dec;

    memcpy_chunk_calc #(
        .BEAT_BYTES      (BEAT_BYTES),
        .MAX_BURST_BEATS (MAX_BURST_BEATS)
    ) u_chunk_calc (
        .rem   (rem_q),
        .src   (src_q[11:0]),
        .dst   (dst_q[11:0]),
        .chunk (calc_chunk),
        .len   (calc_len)
    );

    // Once a command pair is launched it stays valid regardless of the
    // outstanding count or enable, so valids never drop before handshake.
    always_comb begin
        total_al     = pattern_total_number & ~LEN_LOW;
        start        = pattern_memcpy_enable & ~enable_q;
        can_launch   = (out_cnt_q < CNT_W'(MAX_OUTSTANDING)) & pattern_memcpy_enable & ~abort_q;
        issue_live   = (state_q == ST_ISSUE) & (launched_q | can_launch);
        rd_cmd_valid = issue_live & ~rd_hs_q;
        wr_cmd_valid = issue_live & ~wr_hs_q;
        rd_fire      = rd_cmd_valid & rd_cmd_ready;
        wr_fire      = wr_cmd_valid & wr_cmd_ready;
        burst_end    = issue_live & (rd_hs_q | rd_fire) & (wr_hs_q | wr_fire);
        resp_dec     = wr_resp_done & (out_cnt_q != '0);
        cnt_next     = out_cnt_q;
        if (wr_fire && !resp_dec)      cnt_next = out_cnt_q + CNT_W'(1);
        else if (!wr_fire && resp_dec) cnt_next = out_cnt_q - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = (total_al == '0) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                state_d = pattern_memcpy_enable ? ST_ISSUE : ST_DRAIN;
            end
            ST_ISSUE: begin
                if (burst_end) begin
                    if (!pattern_memcpy_enable || abort_q || rem_q == 64'(chunk_q))
                        state_d = ST_DRAIN;
                    else
                        state_d = ST_CALC;
                end else if (!issue_live && !pattern_memcpy_enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_next == '0) state_d = abort_q ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (!pattern_memcpy_enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            chunk_q    <= '0;
            len_q      <= '0;
            rd_hs_q    <= 1'b0;
            wr_hs_q    <= 1'b0;
            launched_q <= 1'b0;
            abort_q    <= 1'b0;
            error_q    <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            enable_q   <= pattern_memcpy_enable;
            out_cnt_q  <= cnt_next;
            launched_q <= issue_live & ~burst_end;
            rd_hs_q    <= (state_q == ST_ISSUE) & ~burst_end & (rd_hs_q | rd_fire);
            wr_hs_q    <= (state_q == ST_ISSUE) & ~burst_end & (wr_hs_q | wr_fire);
            if (state_q == ST_IDLE && start) begin
                src_q   <= pattern_source_address & ~ADDR_LOW;
                dst_q   <= pattern_target_address & ~ADDR_LOW;
                rem_q   <= total_al;
                error_q <= |(pattern_source_address & ADDR_LOW) |
                           |(pattern_target_address & ADDR_LOW) |
                           |(pattern_total_number & LEN_LOW);
                abort_q <= 1'b0;
            end
            if (state_q == ST_CALC) begin
                chunk_q <= calc_chunk;
                len_q   <= calc_len;
            end
            if ((state_q == ST_CALC || state_q == ST_ISSUE) && !pattern_memcpy_enable)
                abort_q <= 1'b1;
            if (burst_end) begin
                src_q <= src_q + ADDR_WIDTH'(chunk_q);
                dst_q <= dst_q + ADDR_WIDTH'(chunk_q);
                rem_q <= rem_q - 64'(chunk_q);
            end
        end
    end

`ifdef MEMCPY_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            perf_q <= '0;
        end else if ((state_q == ST_CALC || state_q == ST_ISSUE || state_q == ST_DRAIN)
                     && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign rd_cmd_addr         = src_q;
    assign rd_cmd_len          = len_q;
    assign wr_cmd_addr         = dst_q;
    assign wr_cmd_len          = len_q;
    assign pattern_memcpy_done = (state_q == ST_DONE);
    assign sched_busy          = (state_q != ST_IDLE);
    assign sched_error         = error_q;

endmodule

// File: tb/tb_memcpy_burst_scheduler.sv
// tb_memcpy_burst_scheduler
//   Directed scenarios plus randomized jobs; expected command streams come
//   from a page-splitting reference model computed with plain arithmetic.
module tb_memcpy_burst_scheduler;

    localparam int unsigned MAX_OUT = 2;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pattern_memcpy_enable;
    logic [63:0] pattern_source_address, pattern_target_address, pattern_total_number;
    logic        rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready;
    logic [63:0] rd_cmd_addr, wr_cmd_addr;
    logic [7:0]  rd_cmd_len, wr_cmd_len;
    logic        wr_resp_done, pattern_memcpy_done, sched_busy, sched_error;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    cmd_t        exp_rd[$], exp_wr[$], rd_obs[$], wr_obs[$];
    logic        exp_err;
    int unsigned rd_base, wr_base;
    int unsigned resp_cnt = 0;
    int unsigned stab_err = 0;
    logic        rd_hold = 1'b0, wr_hold = 1'b0;
    cmd_t        rd_hold_cmd, wr_hold_cmd;

    always #5 clk = ~clk;

    memcpy_burst_scheduler #(
        .ADDR_WIDTH      (64),
        .BEAT_BYTES      (64),
        .MAX_BURST_BEATS (64),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pattern_memcpy_enable  (pattern_memcpy_enable),
        .pattern_source_address (pattern_source_address),
        .pattern_target_address (pattern_target_address),
        .pattern_total_number   (pattern_total_number),
        .rd_cmd_valid           (rd_cmd_valid),
        .rd_cmd_ready           (rd_cmd_ready),
        .rd_cmd_addr            (rd_cmd_addr),
        .rd_cmd_len             (rd_cmd_len),
        .wr_cmd_valid           (wr_cmd_valid),
        .wr_cmd_ready           (wr_cmd_ready),
        .wr_cmd_addr            (wr_cmd_addr),
        .wr_cmd_len             (wr_cmd_len),
        .wr_resp_done           (wr_resp_done),
        .pattern_memcpy_done    (pattern_memcpy_done),
        .sched_busy             (sched_busy),
        .sched_error            (sched_error)
    );

    // Mid-cycle monitor: records handshakes, counts accepted responses and
    // flags any pending command that changes or drops before acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_hold = 1'b0;
            wr_hold = 1'b0;
        end else begin
            if (rd_hold && (!rd_cmd_valid || rd_cmd_addr != rd_hold_cmd.addr || rd_cmd_len != rd_hold_cmd.len))
                stab_err++;
            if (wr_hold && (!wr_cmd_valid || wr_cmd_addr != wr_hold_cmd.addr || wr_cmd_len != wr_hold_cmd.len))
                stab_err++;
            rd_hold     = rd_cmd_valid && !rd_cmd_ready;
            wr_hold     = wr_cmd_valid && !wr_cmd_ready;
            rd_hold_cmd = cmd_t'{addr: rd_cmd_addr, len: rd_cmd_len};
            wr_hold_cmd = cmd_t'{addr: wr_cmd_addr, len: wr_cmd_len};
            if (wr_resp_done && wr_obs.size() > resp_cnt) resp_cnt++;
            if (rd_cmd_valid && rd_cmd_ready) rd_obs.push_back(cmd_t'{addr: rd_cmd_addr, len: rd_cmd_len});
            if (wr_cmd_valid && wr_cmd_ready) wr_obs.push_back(cmd_t'{addr: wr_cmd_addr, len: wr_cmd_len});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned pending();
        return wr_obs.size() - resp_cnt;
    endfunction

    // Reference: walk the job in beat-aligned bytes, cutting at 4 KB on
    // either side and at the 4096-byte burst limit.
    task automatic build_model(input logic [63:0] s, input logic [63:0] d, input logic [63:0] t);
        longint unsigned ss, dd, rr, c;
        exp_rd.delete();
        exp_wr.delete();
        exp_err = (s % 64 != 0) || (d % 64 != 0) || (t % 64 != 0);
        ss = s - (s % 64);
        dd = d - (d % 64);
        rr = t - (t % 64);
        while (rr != 0) begin
            c = (rr > 4096) ? 4096 : rr;
            if (4096 - (ss % 4096) < c) c = 4096 - (ss % 4096);
            if (4096 - (dd % 4096) < c) c = 4096 - (dd % 4096);
            exp_rd.push_back(cmd_t'{addr: ss, len: 8'(c / 64 - 1)});
            exp_wr.push_back(cmd_t'{addr: dd, len: 8'(c / 64 - 1)});
            ss += c;
            dd += c;
            rr -= c;
        end
    endtask

    task automatic start_job(input logic [63:0] s, input logic [63:0] d, input logic [63:0] t);
        build_model(s, d, t);
        rd_base                = rd_obs.size();
        wr_base                = wr_obs.size();
        pattern_source_address = s;
        pattern_target_address = d;
        pattern_total_number   = t;
        pattern_memcpy_enable  = 1'b1;
        tick();
    endtask

    task automatic compare_job(input string tag);
        check({tag, "_rd_count"}, 64'(rd_obs.size() - rd_base), 64'(exp_rd.size()));
        check({tag, "_wr_count"}, 64'(wr_obs.size() - wr_base), 64'(exp_wr.size()));
        for (int i = 0; i < exp_rd.size(); i++) begin
            if (rd_base + i < rd_obs.size()) begin
                check({tag, "_rd_addr"}, rd_obs[rd_base + i].addr, exp_rd[i].addr);
                check({tag, "_rd_len"},  64'(rd_obs[rd_base + i].len), 64'(exp_rd[i].len));
            end
            if (wr_base + i < wr_obs.size()) begin
                check({tag, "_wr_addr"}, wr_obs[wr_base + i].addr, exp_wr[i].addr);
                check({tag, "_wr_len"},  64'(wr_obs[wr_base + i].len), 64'(exp_wr[i].len));
            end
        end
        check({tag, "_stable"}, 64'(stab_err), 64'd0);
    endtask

    task automatic run_until_done(input bit rnd, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            tick();
            wr_resp_done = 1'b0;
            if (pattern_memcpy_done) begin
                seen = 1'b1;
            end else begin
                rd_cmd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                wr_cmd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                wr_resp_done = (pending() > 0) && ($urandom_range(0, 2) == 0);
            end
        end
    endtask

    task automatic wait_wr(input int unsigned n, input string tag);
        int unsigned c = 0;
        while (wr_obs.size() - wr_base < n && c < 50) begin
            tick();
            c++;
        end
        check({tag, "_wr_wait"}, 64'(wr_obs.size() - wr_base >= n), 64'd1);
    endtask

    task automatic end_job(input string tag);
        pattern_memcpy_enable = 1'b0;
        tick();
        check({tag, "_end_done"}, 64'(pattern_memcpy_done), 64'd0);
        check({tag, "_end_busy"}, 64'(sched_busy), 64'd0);
    endtask

    initial begin
        bit          seen;
        logic [63:0] s, d, t;

        rst_n                  = 1'b0;
        pattern_memcpy_enable  = 1'b0;
        pattern_source_address = '0;
        pattern_target_address = '0;
        pattern_total_number   = '0;
        rd_cmd_ready           = 1'b1;
        wr_cmd_ready           = 1'b1;
        wr_resp_done           = 1'b0;
        tick();
        check("rst_busy",  64'(sched_busy), 64'd0);
        check("rst_done",  64'(pattern_memcpy_done), 64'd0);
        check("rst_rd_v",  64'(rd_cmd_valid), 64'd0);
        check("rst_wr_v",  64'(wr_cmd_valid), 64'd0);
        check("rst_error", 64'(sched_error), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Stray response with nothing outstanding must be ignored.
        wr_resp_done = 1'b1;
        tick();
        wr_resp_done = 1'b0;

        // 1: two full page bursts, done one cycle after the second response
        start_job(64'h1000, 64'h20000, 64'd8192);
        wait_wr(2, "t1");
        tick();
        check("t1_busy", 64'(sched_busy), 64'd1);
        check("t1_done_pre", 64'(pattern_memcpy_done), 64'd0);
        wr_resp_done = 1'b1;
        tick();
        wr_resp_done = 1'b0;
        tick();
        check("t1_done_mid", 64'(pattern_memcpy_done), 64'd0);
        wr_resp_done = 1'b1;
        tick();
        wr_resp_done = 1'b0;
        check("t1_done", 64'(pattern_memcpy_done), 64'd1);
        compare_job("t1");
        end_job("t1");

        // 2: source page boundary splits the job
        start_job(64'h0FC0, 64'h10000, 64'd256);
        run_until_done(1'b0, seen);
        check("t2_seen", 64'(seen), 64'd1);
        compare_job("t2");
        end_job("t2");

        // 3: outstanding limit stalls issue until a response returns
        start_job(64'h0, 64'h8000, 64'd16384);
        for (int i = 0; i < 20; i++) tick();
        check("t3_wr_limit", 64'(wr_obs.size() - wr_base), 64'(MAX_OUT));
        check("t3_rd_limit", 64'(rd_obs.size() - rd_base), 64'(MAX_OUT));
        check("t3_rd_v_low", 64'(rd_cmd_valid), 64'd0);
        check("t3_wr_v_low", 64'(wr_cmd_valid), 64'd0);
        wr_resp_done = 1'b1;
        tick();
        wr_resp_done = 1'b0;
        for (int i = 0; i < 2 && wr_obs.size() - wr_base < 3; i++) tick();
        check("t3_third", 64'(wr_obs.size() - wr_base), 64'd3);
        run_until_done(1'b0, seen);
        check("t3_seen", 64'(seen), 64'd1);
        compare_job("t3");
        end_job("t3");

        // 4: zero-length job completes without commands
        start_job(64'h2000, 64'h3000, 64'd0);
        for (int i = 0; i < 2 && !pattern_memcpy_done; i++) tick();
        check("t4_done", 64'(pattern_memcpy_done), 64'd1);
        compare_job("t4");
        end_job("t4");

        // 5: abort after the first pair is accepted
        start_job(64'h4000, 64'h9000, 64'd8192);
        wait_wr(1, "t5");
        pattern_memcpy_enable = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t5_wr_count", 64'(wr_obs.size() - wr_base), 64'd1);
        check("t5_rd_count", 64'(rd_obs.size() - rd_base), 64'd1);
        check("t5_busy", 64'(sched_busy), 64'd1);
        check("t5_done", 64'(pattern_memcpy_done), 64'd0);
        wr_resp_done = 1'b1;
        tick();
        wr_resp_done = 1'b0;
        check("t5_idle_busy", 64'(sched_busy), 64'd0);
        check("t5_idle_done", 64'(pattern_memcpy_done), 64'd0);

        // 6: read side stalled, write side already accepted; misaligned source
        rd_cmd_ready = 1'b0;
        wr_cmd_ready = 1'b1;
        start_job(64'h1004, 64'h3000, 64'd128);
        wait_wr(1, "t6");
        for (int i = 0; i < 5; i++) begin
            check("t6_rd_valid", 64'(rd_cmd_valid), 64'd1);
            check("t6_rd_addr", rd_cmd_addr, exp_rd[0].addr);
            check("t6_wr_valid", 64'(wr_cmd_valid), 64'd0);
            tick();
        end
        check("t6_wr_once", 64'(wr_obs.size() - wr_base), 64'd1);
        check("t6_error", 64'(sched_error), 64'(exp_err));
        run_until_done(1'b0, seen);
        check("t6_seen", 64'(seen), 64'd1);
        compare_job("t6");
        end_job("t6");

        // Reset in the middle of a job; late responses must not disturb the counter
        start_job(64'h5000, 64'h7000, 64'd8192);
        wait_wr(1, "rstmid");
        rst_n = 1'b0;
        pattern_memcpy_enable = 1'b0;
        #2;
        check("rstmid_busy", 64'(sched_busy), 64'd0);
        check("rstmid_rd_v", 64'(rd_cmd_valid), 64'd0);
        check("rstmid_wr_v", 64'(wr_cmd_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4 && pending() > 0; i++) begin
            wr_resp_done = 1'b1;
            tick();
            wr_resp_done = 1'b0;
        end
        tick();

        // Randomized jobs
        for (int j = 0; j < 14; j++) begin
            s = {32'($urandom_range(0, 255)), 32'($urandom_range(0, 32'h000F_FFFF))};
            d = {32'($urandom_range(0, 255)), 32'($urandom_range(0, 32'h000F_FFFF))};
            t = 64'($urandom_range(0, 5 * 4096));
            if ($urandom_range(0, 3) != 0) begin
                s = s & ~64'h3F;
                d = d & ~64'h3F;
                t = t & ~64'h3F;
            end
            start_job(s, d, t);
            run_until_done(1'b1, seen);
            check("rnd_seen", 64'(seen), 64'd1);
            check("rnd_pending", 64'(pending()), 64'd0);
            check("rnd_error", 64'(sched_error), 64'(exp_err));
            compare_job("rnd");
            end_job("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
